// File: rtl/shift_reg8_seq.sv
`timescale 1ns/1ps
// Sequential universal shift unit: applies a 0..7 position shift one bit per clock.
// Latency: out_valid rises shamt+1 edges after the accepting edge (1 for shamt=0, 8 for shamt=7).
// Backpressure: the result is held in DONE until out_ready; in_ready is low outside IDLE.
//
// Optional feature macro: SHIFT_CARRY_EN adds out_carry (last bit shifted out).
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset (priority over everything)
//   in_valid   operand available
//   in_ready   operand accepted this cycle if in_valid (high only in IDLE)
//   in_data    operand
//   in_shamt   shift amount 0..7
//   in_mode    00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result
//   out_data   result register (holds the last result after the transfer)
//   busy       high in SHIFT or DONE
//   out_carry  (SHIFT_CARRY_EN only) last bit shifted out, 0 for shamt = 0
module shift_reg8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef SHIFT_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  // One-position candidates for each mode; the per-bit selector below picks
  // between them exactly as a single barrel-shifter stage would.
  logic [WIDTH-1:0] lsl_dat, lsr_dat, asr_dat, rol_dat;
  logic [WIDTH-1:0] step_dat;

  assign lsl_dat = {data_q[WIDTH-2:0], 1'b0};
  assign lsr_dat = {1'b0, data_q[WIDTH-1:1]};
  assign asr_dat = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
  assign rol_dat = {data_q[WIDTH-2:0], data_q[WIDTH-1]};

  always_comb begin
    step_dat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_q)
        MODE_LSL: step_dat[i] = lsl_dat[i];
        MODE_LSR: step_dat[i] = lsr_dat[i];
        MODE_ASR: step_dat[i] = asr_dat[i];
        default:  step_dat[i] = rol_dat[i];
      endcase
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = in_shamt;
          state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step_dat;
        // Counter starts at 1..7 here, so it reaches 0 exactly as we leave.
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Handshake outputs come from registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;

`ifdef SHIFT_CARRY_EN
  logic carry_q, carry_d;
  logic step_carry;

  // Right shifts lose bit 0; LSL loses bit 7; ROL reports bit 7 (the bit it wraps).
  assign step_carry = ((mode_q == MODE_LSR) || (mode_q == MODE_ASR)) ? data_q[0]
                                                                     : data_q[WIDTH-1];

  always_comb begin
    carry_d = carry_q;
    if ((state_q == ST_IDLE) && in_valid) begin
      carry_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      carry_d = step_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign out_carry = carry_q;
`endif

endmodule
